// File: rtl/pipe_rca_addsub_pkg.sv
// Shared constants and the per-stage pipeline record for the segmented ripple adder.
package pipe_rca_addsub_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;
    // Record fields are sized for the widest supported adder; narrower builds use the low bits.
    localparam int MAX_W     = 64;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] sum;
        logic             carry;
        logic             c_msb;
        logic [MAX_W-1:0] a_rem;
        logic [MAX_W-1:0] b_rem;
    } stage_t;

endpackage

// File: rtl/rca_seg.sv
// SEG-bit combinational ripple-carry adder; also exposes the carry into its top bit.
module rca_seg
    import pipe_rca_addsub_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_rca_addsub.sv
// Pipelined add/subtract: one SEG-bit ripple segment per stage, operands travel skewed with the partial sum.
module pipe_rca_addsub
    import pipe_rca_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || WIDTH > MAX_W || SEG < 1) begin : g_bad_cfg
        $error("pipe_rca_addsub: WIDTH must be a multiple of SEG and at most MAX_W");
    end

    stage_t           st_q [STAGES];
    stage_t           st_d [STAGES];
    stage_t           nxt  [STAGES];
    stage_t           src0;
    logic [WIDTH-1:0] b_eff;
    logic             stall;

    assign stall    = st_q[STAGES-1].valid && !out_ready;
    assign in_ready = !stall;

    // Subtract is A + ~B + 1: invert B up front and force the first carry in.
    always_comb begin
        b_eff                = Sub ? ~B : B;
        src0                 = '0;
        src0.valid           = in_valid;
        src0.carry           = Sub | Cin;
        src0.a_rem[WIDTH-1:0] = A;
        src0.b_rem[WIDTH-1:0] = b_eff;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         src;
        stage_t         nx;
        logic [SEG-1:0] s;
        logic           co;
        logic           cm;

        if (k == 0) begin : g_first
            assign src = src0;
        end else begin : g_rest
            assign src = st_q[k-1];
        end

        rca_seg #(.SEG(SEG)) u_seg (
            .a    (src.a_rem[k*SEG +: SEG]),
            .b    (src.b_rem[k*SEG +: SEG]),
            .cin  (src.carry),
            .s    (s),
            .cout (co),
            .c_msb(cm)
        );

        always_comb begin
            nx                   = src;
            nx.sum[k*SEG +: SEG] = s;
            nx.carry             = co;
            nx.c_msb             = cm;
        end

        assign nxt[k] = nx;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_d[k] = stall ? st_q[k] : nxt[k];
        end
        // No transfer: stage 0 only drops its valid, leaving the last accepted operands untouched.
        if (!stall && !in_valid) begin
            st_d[0]       = st_q[0];
            st_d[0].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            st_q <= st_d;
        end
    end

    assign out_valid = st_q[STAGES-1].valid;
    assign Sum       = st_q[STAGES-1].sum[WIDTH-1:0];
    assign Cout      = st_q[STAGES-1].carry;
    assign Ovf       = st_q[STAGES-1].carry ^ st_q[STAGES-1].c_msb;

endmodule
